// File: rtl/ex_operand_stage.sv
// ID/EX stage register and ALU operand select with load-use / RAW stall control.
// Build option: define EX_FORWARD_EN to enable EX/MEM and MEM/WB operand forwarding.
module ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [WIDTH-1:0]  i_id_rs_data,
  input  logic [WIDTH-1:0]  i_id_rt_data,
  input  logic [WIDTH-1:0]  i_id_imm,
  input  logic              i_id_alu_src,
  input  logic [3:0]        i_id_alu_ctrl,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_mem_write,
  input  logic              i_id_mem_to_reg,
  input  logic              i_flush,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [WIDTH-1:0]  i_exmem_data,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [WIDTH-1:0]  i_memwb_data,
  output logic              o_stall,
  output logic [WIDTH-1:0]  o_src1,
  output logic [WIDTH-1:0]  o_src2,
  output logic [3:0]        o_alu_ctrl,
  output logic [WIDTH-1:0]  o_store_data,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_valid,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_to_reg
);

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [WIDTH-1:0]  ex_rs_data;
  logic [WIDTH-1:0]  ex_rt_data;
  logic [WIDTH-1:0]  ex_imm;
  logic              ex_alu_src;
  logic [3:0]        ex_alu_ctrl;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;

  logic              load_bubble;
  logic              hz_rs;
  logic              hz_rt;
  logic [WIDTH-1:0]  fwd_rs;
  logic [WIDTH-1:0]  fwd_rt;

  // Hazard detection against the instruction currently in EX (and EX/MEM when not forwarding)
  always_comb begin
    hz_rs = 1'b0;
    hz_rt = 1'b0;
`ifdef EX_FORWARD_EN
    if (ex_valid && ex_mem_read && (ex_rd != '0)) begin
      hz_rs = i_id_use_rs && (ex_rd == i_id_rs);
      hz_rt = i_id_use_rt && (ex_rd == i_id_rt);
    end
`else
    if (i_id_use_rs && (i_id_rs != '0)) begin
      hz_rs = (ex_valid && ex_reg_write && (ex_rd == i_id_rs)) ||
              (i_exmem_reg_write && (i_exmem_rd == i_id_rs));
    end
    if (i_id_use_rt && (i_id_rt != '0)) begin
      hz_rt = (ex_valid && ex_reg_write && (ex_rd == i_id_rt)) ||
              (i_exmem_reg_write && (i_exmem_rd == i_id_rt));
    end
`endif
    o_stall = i_id_valid && (hz_rs || hz_rt);
  end

  assign load_bubble = i_flush || o_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_alu_src    <= 1'b0;
      ex_alu_ctrl   <= 4'b0000;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (load_bubble) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_alu_src    <= 1'b0;
      ex_alu_ctrl   <= 4'b0000;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      // Data is captured even for an empty slot; control is gated by i_id_valid
      ex_valid      <= i_id_valid;
      ex_rs         <= i_id_rs;
      ex_rt         <= i_id_rt;
      ex_rd         <= i_id_valid ? i_id_rd : '0;
      ex_rs_data    <= i_id_rs_data;
      ex_rt_data    <= i_id_rt_data;
      ex_imm        <= i_id_imm;
      ex_alu_src    <= i_id_valid && i_id_alu_src;
      ex_alu_ctrl   <= i_id_valid ? i_id_alu_ctrl : 4'b0000;
      ex_reg_write  <= i_id_valid && i_id_reg_write;
      ex_mem_read   <= i_id_valid && i_id_mem_read;
      ex_mem_write  <= i_id_valid && i_id_mem_write;
      ex_mem_to_reg <= i_id_valid && i_id_mem_to_reg;
    end
  end

`ifdef EX_FORWARD_EN
  // Youngest producer wins: EX/MEM before MEM/WB; $0 is never forwarded
  always_comb begin
    fwd_rs = ex_rs_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == ex_rs)) begin
      fwd_rs = i_exmem_data;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == ex_rs)) begin
      fwd_rs = i_memwb_data;
    end
  end

  always_comb begin
    fwd_rt = ex_rt_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == ex_rt)) begin
      fwd_rt = i_exmem_data;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == ex_rt)) begin
      fwd_rt = i_memwb_data;
    end
  end
`else
  assign fwd_rs = ex_rs_data;
  assign fwd_rt = ex_rt_data;
`endif

  assign o_src1       = fwd_rs;
  assign o_src2       = ex_alu_src ? ex_imm : fwd_rt;
  assign o_store_data = fwd_rt;
  assign o_alu_ctrl   = ex_alu_ctrl;
  assign o_rd         = ex_rd;
  assign o_valid      = ex_valid;
  assign o_reg_write  = ex_reg_write;
  assign o_mem_read   = ex_mem_read;
  assign o_mem_write  = ex_mem_write;
  assign o_mem_to_reg = ex_mem_to_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: per-cycle vector table with a scoreboard of expected EX control.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        use_rs, use_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src;
    logic [3:0]  alu;
    logic        rw, mr, mw, m2r;
  } id_t;

  typedef struct packed {
    logic        xwe;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] md;
  } fw_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [3:0]  alu;
  } ctl_t;

  typedef struct packed {
    logic        flush;
    id_t         id;
    fw_t         fw;
    logic        e_stall;
    logic        chk_data;
    logic [31:0] e_src1, e_src2, e_store;
    ctl_t        nx;
  } vec_t;

  logic        clk, rst;
  logic        id_valid, id_use_rs, id_use_rt, id_alu_src;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_data, memwb_data;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, exmem_reg_write, memwb_reg_write;
  logic        stall, valid, reg_write, mem_read, mem_write, mem_to_reg;
  logic [31:0] src1, src2, store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;

  int checks = 0;
  int errors = 0;
  ctl_t sb[$];

  ex_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
    .i_id_alu_src(id_alu_src), .i_id_alu_ctrl(id_alu_ctrl),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_id_mem_write(id_mem_write), .i_id_mem_to_reg(id_mem_to_reg),
    .i_flush(flush),
    .i_exmem_reg_write(exmem_reg_write), .i_exmem_rd(exmem_rd), .i_exmem_data(exmem_data),
    .i_memwb_reg_write(memwb_reg_write), .i_memwb_rd(memwb_rd), .i_memwb_data(memwb_data),
    .o_stall(stall), .o_src1(src1), .o_src2(src2), .o_alu_ctrl(alu_ctrl),
    .o_store_data(store_data), .o_rd(rd), .o_valid(valid), .o_reg_write(reg_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_t idf(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rdn,
                              logic urs, logic urt, logic [31:0] rsd, logic [31:0] rtd,
                              logic [31:0] imm, logic asrc, logic [3:0] alu,
                              logic rw, logic mr, logic mw, logic m2r);
    id_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.rd = rdn; r.use_rs = urs; r.use_rt = urt;
    r.rs_data = rsd; r.rt_data = rtd; r.imm = imm; r.alu_src = asrc; r.alu = alu;
    r.rw = rw; r.mr = mr; r.mw = mw; r.m2r = m2r;
    return r;
  endfunction

  function automatic fw_t fwf(logic xwe, logic [4:0] xrd, logic [31:0] xd,
                              logic mwe, logic [4:0] mrd, logic [31:0] md);
    fw_t r;
    r.xwe = xwe; r.xrd = xrd; r.xd = xd; r.mwe = mwe; r.mrd = mrd; r.md = md;
    return r;
  endfunction

  function automatic ctl_t cf(logic v, logic [4:0] rdn, logic rw, logic mr, logic [3:0] alu);
    ctl_t r;
    r.valid = v; r.rd = rdn; r.rw = rw; r.mr = mr; r.alu = alu;
    return r;
  endfunction

  function automatic vec_t vf(logic fl, id_t id, fw_t fw, logic st, logic cd,
                              logic [31:0] s1, logic [31:0] s2, logic [31:0] sd, ctl_t nx);
    vec_t r;
    r.flush = fl; r.id = id; r.fw = fw; r.e_stall = st; r.chk_data = cd;
    r.e_src1 = s1; r.e_src2 = s2; r.e_store = sd; r.nx = nx;
    return r;
  endfunction

  task automatic apply(input vec_t r);
    flush = r.flush;
    id_valid = r.id.valid; id_rs = r.id.rs; id_rt = r.id.rt; id_rd = r.id.rd;
    id_use_rs = r.id.use_rs; id_use_rt = r.id.use_rt;
    id_rs_data = r.id.rs_data; id_rt_data = r.id.rt_data; id_imm = r.id.imm;
    id_alu_src = r.id.alu_src; id_alu_ctrl = r.id.alu;
    id_reg_write = r.id.rw; id_mem_read = r.id.mr; id_mem_write = r.id.mw; id_mem_to_reg = r.id.m2r;
    exmem_reg_write = r.fw.xwe; exmem_rd = r.fw.xrd; exmem_data = r.fw.xd;
    memwb_reg_write = r.fw.mwe; memwb_rd = r.fw.mrd; memwb_data = r.fw.md;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, {31'b0, valid}, 32'h0);
    chk({tag, " reg_write"}, {31'b0, reg_write}, 32'h0);
    chk({tag, " mem_read"}, {31'b0, mem_read}, 32'h0);
    chk({tag, " mem_write"}, {31'b0, mem_write}, 32'h0);
    chk({tag, " mem_to_reg"}, {31'b0, mem_to_reg}, 32'h0);
    chk({tag, " rd"}, {27'b0, rd}, 32'h0);
    chk({tag, " alu_ctrl"}, {28'b0, alu_ctrl}, 32'h0);
    chk({tag, " src1"}, src1, 32'h0);
    chk({tag, " src2"}, src2, 32'h0);
    chk({tag, " store"}, store_data, 32'h0);
    chk({tag, " stall"}, {31'b0, stall}, 32'h0);
  endtask

`ifdef EX_FORWARD_EN
  localparam int N = 12;
`else
  localparam int N = 14;
`endif
  vec_t tbl[N];
  id_t  noid;
  fw_t  nofw;
  ctl_t bub;

  initial begin
    noid = idf(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nofw = fwf(0, 0, 0, 0, 0, 0);
    bub  = cf(0, 0, 0, 0, 0);
`ifdef EX_FORWARD_EN
    tbl[0]  = vf(0, idf(1,1,2,3,1,1,5,7,0,0,4'd0,1,0,0,0), nofw, 0, 1, 0, 0, 0, cf(1,3,1,0,4'd0));
    tbl[1]  = vf(0, idf(1,3,5,4,1,1,0,9,0,0,4'd1,1,0,0,0), nofw, 0, 1, 5, 7, 7, cf(1,4,1,0,4'd1));
    tbl[2]  = vf(0, idf(1,1,2,2,1,0,32'h100,32'h22,4,1,4'd0,1,1,0,1), fwf(1,3,32'h10,0,0,0),
                 0, 1, 32'h10, 9, 9, cf(1,2,1,1,4'd0));
    tbl[3]  = vf(0, idf(1,2,2,5,1,1,0,0,0,0,4'd0,1,0,0,0), fwf(1,4,1,0,0,0),
                 1, 1, 32'h100, 4, 32'h22, bub);
    tbl[4]  = vf(0, idf(1,2,2,5,1,1,0,0,0,0,4'd0,1,0,0,0), fwf(1,2,32'h104,0,0,0),
                 0, 1, 0, 0, 0, cf(1,5,1,0,4'd0));
    tbl[5]  = vf(0, idf(1,5,7,7,1,0,0,0,0,1,4'd0,1,1,0,1), fwf(0,0,0,1,2,32'hBEEF),
                 0, 1, 32'hBEEF, 32'hBEEF, 32'hBEEF, cf(1,7,1,1,4'd0));
    tbl[6]  = vf(1, idf(1,7,0,8,1,1,0,0,0,0,4'd0,1,0,0,0), fwf(1,5,32'h177DE,0,0,0),
                 1, 1, 32'h177DE, 0, 0, bub);
    tbl[7]  = vf(0, idf(1,3,3,9,1,0,32'h10,32'h44,32'hFFFF_FFFC,1,4'd0,1,0,0,0),
                 fwf(1,7,32'h177DE,0,0,0), 0, 1, 0, 0, 0, cf(1,9,1,0,4'd0));
    tbl[8]  = vf(0, idf(1,3,0,10,1,1,32'h11,32'h66,0,0,4'd1,1,0,0,0),
                 fwf(1,3,32'hAAAA_AAAA,1,3,32'h5555_5555), 0, 1,
                 32'hAAAA_AAAA, 32'hFFFF_FFFC, 32'hAAAA_AAAA, cf(1,10,1,0,4'd1));
    tbl[9]  = vf(0, idf(0,3,3,0,1,1,0,0,0,0,4'd0,0,0,0,0),
                 fwf(1,0,32'hDEAD,1,3,32'h5555_5555), 0, 1,
                 32'h5555_5555, 32'h66, 32'h66, bub);
    tbl[10] = vf(0, idf(1,1,0,0,1,0,0,0,0,1,4'd0,1,1,0,1), nofw, 0, 0, 0, 0, 0, cf(1,0,1,1,4'd0));
    tbl[11] = vf(0, idf(1,0,0,11,1,1,0,0,0,0,4'd0,1,0,0,0), nofw, 0, 0, 0, 0, 0, cf(1,11,1,0,4'd0));
`else
    tbl[0]  = vf(0, idf(1,1,2,3,1,1,5,7,0,0,4'd0,1,0,0,0), nofw, 0, 1, 0, 0, 0, cf(1,3,1,0,4'd0));
    tbl[1]  = vf(0, idf(1,3,5,4,1,1,0,9,0,0,4'd1,1,0,0,0), nofw, 1, 1, 5, 7, 7, bub);
    tbl[2]  = vf(0, idf(1,3,5,4,1,1,0,9,0,0,4'd1,1,0,0,0), fwf(1,3,32'h10,0,0,0),
                 1, 1, 0, 0, 0, bub);
    tbl[3]  = vf(0, idf(1,3,5,4,1,1,32'h10,9,0,0,4'd1,1,0,0,0), fwf(0,0,0,1,3,32'h10),
                 0, 1, 0, 0, 0, cf(1,4,1,0,4'd1));
    tbl[4]  = vf(0, idf(1,1,2,2,1,0,32'h100,32'h22,0,1,4'd0,1,1,0,1), nofw,
                 0, 1, 32'h10, 9, 9, cf(1,2,1,1,4'd0));
    tbl[5]  = vf(0, idf(1,2,2,5,1,1,0,0,0,0,4'd0,1,0,0,0), fwf(1,4,1,0,0,0),
                 1, 1, 32'h100, 0, 32'h22, bub);
    tbl[6]  = vf(0, idf(1,2,2,5,1,1,0,0,0,0,4'd0,1,0,0,0), fwf(1,2,32'h104,0,0,0),
                 1, 1, 0, 0, 0, bub);
    tbl[7]  = vf(0, idf(1,2,2,5,1,1,32'hBEEF,32'hBEEF,0,0,4'd0,1,0,0,0), fwf(0,0,0,1,2,32'hBEEF),
                 0, 1, 0, 0, 0, cf(1,5,1,0,4'd0));
    tbl[8]  = vf(1, idf(1,5,6,6,1,0,0,32'h33,32'hFFFF_FFFC,1,4'd0,1,0,0,0), nofw,
                 1, 1, 32'hBEEF, 32'hBEEF, 32'hBEEF, bub);
    tbl[9]  = vf(0, idf(1,5,6,6,1,0,0,32'h33,32'hFFFF_FFFC,1,4'd0,1,0,0,0),
                 fwf(1,5,32'h177DE,0,0,0), 1, 1, 0, 0, 0, bub);
    tbl[10] = vf(0, idf(1,5,6,6,1,0,32'h177DE,32'h33,32'hFFFF_FFFC,1,4'd0,1,0,0,0),
                 fwf(0,0,0,1,5,32'h177DE), 0, 1, 0, 0, 0, cf(1,6,1,0,4'd0));
    tbl[11] = vf(0, idf(0,6,6,0,1,1,0,0,0,0,4'd0,0,0,0,0), nofw,
                 0, 1, 32'h177DE, 32'hFFFF_FFFC, 32'h33, bub);
    tbl[12] = vf(0, idf(1,7,7,0,1,0,0,0,0,0,4'd0,1,0,0,0), fwf(1,0,32'hDEAD,0,0,0),
                 0, 0, 0, 0, 0, cf(1,0,1,0,4'd0));
    tbl[13] = vf(0, idf(1,0,0,8,1,1,0,0,0,0,4'd0,0,0,0,0), fwf(1,0,32'hDEAD,0,0,0),
                 0, 0, 0, 0, 0, cf(1,8,0,0,4'd0));
`endif

    rst = 1'b1;
    apply(vf(0, noid, nofw, 0, 0, 0, 0, 0, bub));
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      ctl_t c;
      @(negedge clk);
      apply(tbl[k]);
      #1;
      chk($sformatf("r%0d stall", k), {31'b0, stall}, {31'b0, tbl[k].e_stall});
      if (tbl[k].chk_data) begin
        chk($sformatf("r%0d src1", k), src1, tbl[k].e_src1);
        chk($sformatf("r%0d src2", k), src2, tbl[k].e_src2);
        chk($sformatf("r%0d store", k), store_data, tbl[k].e_store);
      end
      sb.push_back(tbl[k].nx);
      @(posedge clk);
      #1;
      c = sb.pop_front();
      chk($sformatf("r%0d valid", k), {31'b0, valid}, {31'b0, c.valid});
      chk($sformatf("r%0d rd", k), {27'b0, rd}, {27'b0, c.rd});
      chk($sformatf("r%0d reg_write", k), {31'b0, reg_write}, {31'b0, c.rw});
      chk($sformatf("r%0d mem_read", k), {31'b0, mem_read}, {31'b0, c.mr});
      chk($sformatf("r%0d alu_ctrl", k), {28'b0, alu_ctrl}, {28'b0, c.alu});
    end

    // Reset while a load-use stall is pending
    @(negedge clk);
    apply(vf(0, idf(1,1,2,2,1,0,32'h40,0,0,1,4'd0,1,1,0,1), nofw, 0, 0, 0, 0, 0, bub));
    @(negedge clk);
    apply(vf(0, idf(1,2,2,5,1,1,0,0,0,0,4'd0,1,0,0,0), nofw, 0, 0, 0, 0, 0, bub));
    #1;
    chk("pre-reset stall", {31'b0, stall}, 32'h1);
    chk("pre-reset mem_read", {31'b0, mem_read}, 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid-stall reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("post-reset valid", {31'b0, valid}, 32'h1);
    chk("post-reset rd", {27'b0, rd}, 32'h5);
    chk("scoreboard drained", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
